instr_queue: RTL and testbench

INSTR_QUEUE -- requirements
Module: instr_queue

---
 rtl/instr_queue_pkg.sv | 22 ++
 rtl/instr_queue_ctrl.sv | 95 +++++++++
 rtl/instr_queue.sv | 124 ++++++++++++
 tb/tb_instr_queue.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/instr_queue_pkg.sv
// Shared types for the instruction queue: opcode encoding and queue mode.
package instr_queue_pkg;

    localparam int unsigned OPC_W = 4;

    typedef enum logic [OPC_W-1:0] {
        ZERO  = 4'd0,
        ADD   = 4'd1,
        SUB   = 4'd2,
        MUL   = 4'd3,
        LOAD  = 4'd4,
        STORE = 4'd5,
        JUMP  = 4'd6,
        NOP   = 4'd7
    } opcode_t;

    typedef enum logic {
        RAM  = 1'b0,
        FIFO = 1'b1
    } qmode_t;

endpackage

// File: rtl/instr_queue_ctrl.sv
// Queue control: FIFO pointers, occupancy count, sticky error flags and
// mode tracking with flush on mode change.
module instr_queue_ctrl
    import instr_queue_pkg::*;
#(
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  qmode_t           mode_i,
    input  logic             load_en_i,
    input  logic             pop_i,
    input  logic             clr_err_i,
    output qmode_t           mode_q_o,
    output logic             flush_o,
    output logic             wr_acc_o,
    output logic             pop_acc_o,
    output logic [PTR_W-1:0] wr_ptr_o,
    output logic [PTR_W-1:0] rd_ptr_o,
    output logic [PTR_W:0]   count_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             overflow_o,
    output logic             underflow_o
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic             seen_q;
    qmode_t           mode_q;
    logic             flush, fifo_op, cnt_full, cnt_empty;
    logic             wr_acc, pop_acc, ovf_evt, unf_evt;

    assign cnt_full  = (count_q == (PTR_W+1)'(DEPTH));
    assign cnt_empty = (count_q == '0);

    // seen_q masks the first cycle after reset so the mode is captured without a flush
    always_comb begin
        flush    = seen_q && (mode_i != mode_q);
        fifo_op  = !flush && (mode_i == FIFO);
        wr_acc   = fifo_op && load_en_i && (!cnt_full || pop_i);
        pop_acc  = fifo_op && pop_i && !cnt_empty;
        ovf_evt  = fifo_op && load_en_i && cnt_full && !pop_i;
        unf_evt  = fifo_op && pop_i && cnt_empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc)  wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_acc) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + (PTR_W+1)'(wr_acc) - (PTR_W+1)'(pop_acc);
        end
        ovf_d = ovf_evt || (ovf_q && !clr_err_i);
        unf_d = unf_evt || (unf_q && !clr_err_i);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            seen_q   <= 1'b0;
            mode_q   <= RAM;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            seen_q   <= 1'b1;
            mode_q   <= mode_i;
        end
    end

    assign mode_q_o    = mode_q;
    assign flush_o     = flush;
    assign wr_acc_o    = wr_acc;
    assign pop_acc_o   = pop_acc;
    assign wr_ptr_o    = wr_ptr_q;
    assign rd_ptr_o    = rd_ptr_q;
    assign count_o     = count_q;
    assign full_o      = (mode_q == FIFO) && cnt_full;
    assign empty_o     = (mode_q == RAM) || cnt_empty;
    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;

endmodule

// File: rtl/instr_queue.sv
// Instruction store usable as random-access RAM or as a FIFO, with a
// combinational read path. Optional parity: define INSTR_QUEUE_PARITY_EN.
module instr_queue
    import instr_queue_pkg::*;
#(
    parameter  int unsigned DEPTH    = 16,
    parameter  int unsigned OP_WIDTH = 4,
    localparam int unsigned PTR_W    = $clog2(DEPTH),
    localparam int unsigned WORD_W   = OPC_W + 2 * OP_WIDTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mode,
    input  logic                load_en,
    input  opcode_t             opcode,
    input  logic [OP_WIDTH-1:0] operand_a,
    input  logic [OP_WIDTH-1:0] operand_b,
    input  logic [PTR_W-1:0]    write_pointer,
    input  logic [PTR_W-1:0]    read_pointer,
    input  logic                pop,
    input  logic                clr_err,
    output logic [WORD_W-1:0]   instruction_word,
    output logic                valid,
    output logic                full,
    output logic                empty,
    output logic [PTR_W:0]      count,
    output logic                overflow,
    output logic                underflow,
    output logic                parity_err
);

    typedef struct packed {
        opcode_t             opc;
        logic [OP_WIDTH-1:0] op_a;
        logic [OP_WIDTH-1:0] op_b;
    } entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             wdata;
    logic [DEPTH-1:0]   vld_q, vld_d;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr, waddr, caddr, raddr;
    logic               we, clr;
    logic               flush, wr_acc, pop_acc;
    qmode_t             mode_q;

    instr_queue_ctrl #(.DEPTH(DEPTH)) u_ctrl (
        .clk         (clk),
        .reset       (reset),
        .mode_i      (qmode_t'(mode)),
        .load_en_i   (load_en),
        .pop_i       (pop),
        .clr_err_i   (clr_err),
        .mode_q_o    (mode_q),
        .flush_o     (flush),
        .wr_acc_o    (wr_acc),
        .pop_acc_o   (pop_acc),
        .wr_ptr_o    (wr_ptr),
        .rd_ptr_o    (rd_ptr),
        .count_o     (count),
        .full_o      (full),
        .empty_o     (empty),
        .overflow_o  (overflow),
        .underflow_o (underflow)
    );

    assign wdata = '{opc: opcode, op_a: operand_a, op_b: operand_b};

    // Write/invalidate selection; the write is applied last so it wins on a same-index clash
    always_comb begin
        we    = 1'b0;
        clr   = 1'b0;
        waddr = write_pointer;
        caddr = read_pointer;
        if (!flush) begin
            if (mode == FIFO) begin
                we    = wr_acc;
                clr   = pop_acc;
                waddr = wr_ptr;
                caddr = rd_ptr;
            end else begin
                we  = load_en;
                clr = pop;
            end
        end
        vld_d = vld_q;
        if (flush) begin
            vld_d = '0;
        end else begin
            if (clr) vld_d[caddr] = 1'b0;
            if (we)  vld_d[waddr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '{opc: ZERO, op_a: '0, op_b: '0};
        end else begin
            vld_q <= vld_d;
            if (we) mem_q[waddr] <= wdata;
        end
    end

    assign raddr            = (mode_q == FIFO) ? rd_ptr : read_pointer;
    assign instruction_word = mem_q[raddr];
    assign valid            = (mode_q == FIFO) ? (count != '0) : vld_q[raddr];

`ifdef INSTR_QUEUE_PARITY_EN
    logic [DEPTH-1:0] par_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            par_q <= '0;
        end else if (we) begin
            par_q[waddr] <= ^wdata;
        end
    end

    assign parity_err = valid && ((^mem_q[raddr]) != par_q[raddr]);
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_queue.sv
// Directed self-checking bench for instr_queue (DEPTH=16, OP_WIDTH=4).
module tb_instr_queue;
    import instr_queue_pkg::*;

    logic        clk = 1'b0;
    logic        reset, mode, load_en, pop, clr_err;
    opcode_t     opcode;
    logic [3:0]  operand_a, operand_b, write_pointer, read_pointer;
    logic [11:0] instruction_word;
    logic        valid, full, empty, overflow, underflow, parity_err;
    logic [4:0]  count;

    int n_run  = 0;
    int n_fail = 0;

    typedef struct {
        logic       ld;
        logic [3:0] wp;
        opcode_t    opc;
        logic [3:0] a;
        logic [3:0] b;
        logic       pp;
        logic [3:0] rp;
        logic       ev;
        logic [11:0] ew;
    } vec_t;

    vec_t tbl [9];

    instr_queue dut (
        .clk              (clk),
        .reset            (reset),
        .mode             (mode),
        .load_en          (load_en),
        .opcode           (opcode),
        .operand_a        (operand_a),
        .operand_b        (operand_b),
        .write_pointer    (write_pointer),
        .read_pointer     (read_pointer),
        .pop              (pop),
        .clr_err          (clr_err),
        .instruction_word (instruction_word),
        .valid            (valid),
        .full             (full),
        .empty            (empty),
        .count            (count),
        .overflow         (overflow),
        .underflow        (underflow),
        .parity_err       (parity_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        load_en = 1'b0;
        pop     = 1'b0;
        clr_err = 1'b0;
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fifo_load(input logic [3:0] a, input logic [3:0] b, input logic with_pop);
        opcode    = ADD;
        operand_a = a;
        operand_b = b;
        load_en   = 1'b1;
        pop       = with_pop;
        tick();
    endtask

    initial begin
        tbl[0] = '{1'b1, 4'd7,  ADD,   4'd3,  4'd5, 1'b0, 4'd7,  1'b1, 12'h135};
        tbl[1] = '{1'b0, 4'd0,  ZERO,  4'd0,  4'd0, 1'b0, 4'd6,  1'b0, 12'h000};
        tbl[2] = '{1'b1, 4'd6,  SUB,   4'd15, 4'd1, 1'b0, 4'd6,  1'b1, 12'h2F1};
        tbl[3] = '{1'b0, 4'd0,  ZERO,  4'd0,  4'd0, 1'b1, 4'd7,  1'b0, 12'h135};
        tbl[4] = '{1'b1, 4'd7,  MUL,   4'd2,  4'd2, 1'b1, 4'd7,  1'b1, 12'h322};
        tbl[5] = '{1'b1, 4'd0,  LOAD,  4'd1,  4'd0, 1'b0, 4'd0,  1'b1, 12'h410};
        tbl[6] = '{1'b1, 4'd15, STORE, 4'd8,  4'd9, 1'b0, 4'd15, 1'b1, 12'h589};
        tbl[7] = '{1'b0, 4'd0,  ZERO,  4'd0,  4'd0, 1'b0, 4'd7,  1'b1, 12'h322};
        tbl[8] = '{1'b1, 4'd5,  ADD,   4'd1,  4'd1, 1'b1, 4'd6,  1'b0, 12'h2F1};

        reset = 1'b1; mode = 1'b0; load_en = 1'b0; pop = 1'b0; clr_err = 1'b0;
        opcode = ADD; operand_a = 4'd1; operand_b = 4'd1;
        write_pointer = 4'd0; read_pointer = 4'd0;
        tick();
        load_en = 1'b1;
        tick();
        chk("rst_valid", int'(valid), 0);
        chk("rst_word", int'(instruction_word), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_full", int'(full), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_unf", int'(underflow), 0);
        chk("rst_par", int'(parity_err), 0);
        reset = 1'b0;

        // RAM-mode vectors
        for (int i = 0; i < 9; i++) begin
            load_en       = tbl[i].ld;
            write_pointer = tbl[i].wp;
            opcode        = tbl[i].opc;
            operand_a     = tbl[i].a;
            operand_b     = tbl[i].b;
            pop           = tbl[i].pp;
            read_pointer  = tbl[i].rp;
            tick();
            chk($sformatf("ram%0d_valid", i), int'(valid), int'(tbl[i].ev));
            chk($sformatf("ram%0d_word", i), int'(instruction_word), int'(tbl[i].ew));
            chk($sformatf("ram%0d_full", i), int'(full), 0);
            chk($sformatf("ram%0d_empty", i), int'(empty), 1);
            chk($sformatf("ram%0d_par", i), int'(parity_err), 0);
        end

        // switch to FIFO: flush cycle ignores the load
        mode = 1'b1; load_en = 1'b1;
        tick();
        chk("flush_count", int'(count), 0);
        chk("flush_valid", int'(valid), 0);
        chk("flush_empty", int'(empty), 1);

        for (int i = 0; i < 16; i++) fifo_load(4'(i), 4'd0, 1'b0);
        chk("fill_full", int'(full), 1);
        chk("fill_count", int'(count), 16);
        chk("fill_head", int'(instruction_word), 12'h100);
        fifo_load(4'd14, 4'd14, 1'b0);
        chk("ovf_set", int'(overflow), 1);
        chk("ovf_count", int'(count), 16);
        clr_err = 1'b1;
        tick();
        chk("ovf_clr", int'(overflow), 0);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("pop%0d_word", i), int'(instruction_word), int'({4'd1, 4'(i), 4'd0}));
            pop = 1'b1;
            tick();
        end
        chk("drain_empty", int'(empty), 1);
        chk("drain_valid", int'(valid), 0);
        chk("drain_count", int'(count), 0);

        // full with simultaneous load and pop
        for (int i = 0; i < 16; i++) fifo_load(4'(i), 4'd0, 1'b0);
        fifo_load(4'd9, 4'hF, 1'b1);
        chk("lp_count", int'(count), 16);
        chk("lp_ovf", int'(overflow), 0);
        chk("lp_full", int'(full), 1);
        for (int i = 1; i < 16; i++) begin
            chk($sformatf("lp_pop%0d", i), int'(instruction_word), int'({4'd1, 4'(i), 4'd0}));
            pop = 1'b1;
            tick();
        end
        chk("lp_last", int'(instruction_word), 12'h19F);
        pop = 1'b1;
        tick();
        chk("lp_empty", int'(empty), 1);

        // underflow cases
        pop = 1'b1;
        tick();
        chk("unf_set", int'(underflow), 1);
        chk("unf_count", int'(count), 0);
        fifo_load(4'd4, 4'd2, 1'b1);
        chk("unf_ld_count", int'(count), 1);
        chk("unf_ld_flag", int'(underflow), 1);
        chk("unf_ld_word", int'(instruction_word), 12'h142);
        chk("unf_ld_valid", int'(valid), 1);
        clr_err = 1'b1;
        tick();
        chk("unf_clr", int'(underflow), 0);
        chk("unf_clr_count", int'(count), 1);
        pop = 1'b1;
        tick();
        chk("unf_pop_empty", int'(empty), 1);
        pop = 1'b1; clr_err = 1'b1;
        tick();
        chk("unf_clr_vs_set", int'(underflow), 1);

        // mode toggle with three entries flushes, flags kept
        for (int i = 0; i < 3; i++) fifo_load(4'(i + 5), 4'd0, 1'b0);
        chk("pre_tog_count", int'(count), 3);
        mode = 1'b0; load_en = 1'b1; write_pointer = 4'd3; pop = 1'b1;
        tick();
        chk("tog_count", int'(count), 0);
        chk("tog_unf", int'(underflow), 1);
        chk("tog_ovf", int'(overflow), 0);
        chk("tog_empty", int'(empty), 1);
        for (int i = 0; i < 16; i++) begin
            read_pointer = 4'(i);
            #1;
            chk($sformatf("tog_vld%0d", i), int'(valid), 0);
        end

        // parity on a RAM entry
        opcode = MUL; operand_a = 4'd2; operand_b = 4'd2;
        write_pointer = 4'd7; read_pointer = 4'd7; load_en = 1'b1;
        tick();
        chk("par_word", int'(instruction_word), 12'h322);
        chk("par_clean", int'(parity_err), 0);
`ifdef INSTR_QUEUE_PARITY_EN
        dut.mem_q[7].op_b = dut.mem_q[7].op_b ^ 4'd1;
        #1;
        chk("par_flip", int'(parity_err), 1);
`else
        chk("par_tied", int'(parity_err), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
